seq_div_32: RTL and testbench
=============================

# seq_div_32

Multi-cycle 32-bit integer divider for the CS147 datapath. It sits directly downstream of the ripple-carry adder/subtractor and consumes it: each iteration issues one trial subtraction through an `RC_ADD_SUB_32` instance. The block returns quotient and remainder using a start/done handshake. The ALU/control unit uses it to execute DIV/REM without a combinational divider.

## Interface
- `WIDTH`, default 32 (`DATA_WIDTH`): operand width; only 32 is supported and verified.
- `CLK`, input, 1: sole clock; all state updates on the rising edge.
- `RST`, input, 1: reset; asynchronous, active-high.
- `START`, input, 1: request; sampled only in IDLE.
- `DVND`, input, 32: dividend; sampled on the START edge.
- `DVSR`, input, 32: divisor; sampled on the START edge.
- `SIGNED`, input, 1: operands are two's complement; sampled on the START edge.
- `QUOT`, output, 32: registered quotient; holds until next completion.
- `REM`, output, 32: registered remainder; holds until next completion.
- `DONE`, output, 1: one-cycle completion pulse.
- `BUSY`, output, 1: high while in RUN or FIX.
- `DIV_BY_ZERO`, output, 1: set with DONE when DVSR was 0; holds until next completion.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**
  - START=1 and DVSR≠0: load |DVND| into Q and |DVSR| into D (absolute values only when signed mode is active). Clear R (32b) and set CNT=32. Latch sign flags: negQ = signDVND^signDVSR, negR = signDVND. Go to RUN.
  - START=1 and DVSR=0: QUOT=0xFFFFFFFF, REM=DVND, DIV_BY_ZERO=1, DONE=1. Stay in IDLE.
- **RUN** (one bit per cycle)
  - Shift {R,Q} left by 1; `msb` is the bit shifted out of R.
  - Trial T = R_shift − D via `RC_ADD_SUB_32` (SnA=1); CO=1 means no borrow.
  - Accept = msb | CO. If accepted: R=T and Q[0]=1. Otherwise: R=R_shift and Q[0]=0.
  - Decrement CNT; go to FIX after the iteration in which CNT reaches 0.
- **FIX**
  - QUOT = negQ ? −Q : Q; REM = negR ? −R : R.
  - DIV_BY_ZERO=0, DONE=1; go to IDLE.
- Negation uses two more `RC_ADD_SUB_32` instances (A=0, SnA=1). They are muxed between operand conditioning (IDLE) and result fixing (FIX).
- Overflow case 0x80000000 / −1 (signed) yields QUOT=0x80000000, REM=0 with no special handling.
- START while BUSY is ignored. Operand inputs are don't-care outside the START edge.
- DONE is registered and high for exactly one cycle. START may be asserted in the DONE cycle, since the state is already IDLE.

## Timing
- START accepted at edge k → RUN on edges k+1..k+32 → FIX at edge k+33. DONE, QUOT, REM and DIV_BY_ZERO update at edge k+33. Latency is 33 edges, throughput one op per 34 cycles.
- Divide-by-zero completes in 1 edge: DONE is high in the cycle after edge k.
- BUSY is high from edge k until edge k+33. It is low in the DONE cycle.
- RST (async) at any time, including mid-RUN: state=IDLE, QUOT=0, REM=0, DONE=0, BUSY=0, DIV_BY_ZERO=0, CNT=0, and internal R/Q/D cleared. The in-flight operation is discarded and no DONE is produced.

## Configuration
- `SEQ_DIV_SIGNED_EN` defined: SIGNED=1 selects two's-complement division. Quotient truncates toward zero; remainder takes the dividend's sign.
- Undefined: the SIGNED port remains but is ignored. All operations are unsigned and the negation instances and sign flags are not built.

## Structure
- `prj_definition.v` holds `DATA_WIDTH`/`DATA_INDEX_LIMIT` and the state encodings `DIV_ST_IDLE`, `DIV_ST_RUN`, `DIV_ST_FIX` (2 bits).
- Sub-module: existing `RC_ADD_SUB_32`, with one instance for the trial subtract and two for negation (signed build only). No other sub-modules; the control FSM, counter and registers live in `seq_div_32`.

## Test plan
- Unsigned 100/7, SIGNED=0 → QUOT=14, REM=2, DIV_BY_ZERO=0, DONE exactly 33 edges after START, BUSY high for 33 cycles.
- Unsigned 0xFFFFFFFF/1 → QUOT=0xFFFFFFFF, REM=0 (exercises the msb shift-out accept path).
- 0x1234/0 → QUOT=0xFFFFFFFF, REM=0x1234, DIV_BY_ZERO=1, DONE after 1 edge, BUSY never high.
- Macro on, SIGNED=1: −7/2 → QUOT=0xFFFFFFFD, REM=0xFFFFFFFF; 0x80000000/0xFFFFFFFF → QUOT=0x80000000, REM=0.
- Macro off, SIGNED=1: 0xFFFFFFF9/2 → QUOT=0x7FFFFFFC, REM=1.
- Assert RST 10 cycles into RUN → all outputs 0 immediately, no DONE. START pulsed during BUSY of a following op is ignored, and that op's result is unchanged.

Source files
------------

// File: rtl/seq_div_32_pkg.sv
// seq_div_32 shared definitions: datapath width and divider FSM states.
// Used by the divider and the ripple-carry adder/subtractor.
package seq_div_32_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int DATA_INDEX_LIMIT = DATA_WIDTH - 1;
  localparam int CNT_W            = 6;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_RUN  = 2'd1,
    DIV_ST_FIX  = 2'd2
  } div_st_e;

endpackage

// File: rtl/seq_div_32_rc_add_sub.sv
// RC_ADD_SUB_32: 32-bit ripple-carry adder/subtractor.
// SnA=1 computes A-B with CO=1 meaning no borrow.
module RC_ADD_SUB_32
  import seq_div_32_pkg::*;
(
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  CO,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  SnA
);

  always_comb begin
    logic c;
    logic bx;
    c  = SnA;
    bx = 1'b0;
    Y  = '0;
    for (int i = 0; i <= DATA_INDEX_LIMIT; i++) begin
      bx   = B[i] ^ SnA;
      Y[i] = A[i] ^ bx ^ c;
      c    = (A[i] & bx) | (c & (A[i] ^ bx));
    end
    CO = c;
  end

endmodule

// File: rtl/seq_div_32.sv
// seq_div_32: restoring shift/subtract divider, one quotient bit per cycle.
// Define SEQ_DIV_SIGNED_EN to build the two's-complement (SIGNED=1) mode.
module seq_div_32
  import seq_div_32_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DVND,
  input  logic [WIDTH-1:0] DVSR,
  input  logic             SIGNED,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             DONE,
  output logic             BUSY,
  output logic             DIV_BY_ZERO
);

  div_st_e          st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] r_sh, q_sh, trial;
  logic             msb, trial_co, accept;
  logic [WIDTH-1:0] dvnd_abs, dvsr_abs;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic             go;

  assign go = (st_q == DIV_ST_IDLE)
            & START & (DVSR != '0);

  assign {msb, r_sh, q_sh} = {r_q, q_q, 1'b0};

  RC_ADD_SUB_32 u_trial (
    .Y   (trial),
    .CO  (trial_co),
    .A   (r_sh),
    .B   (d_q),
    .SnA (1'b1)
  );

  assign accept = msb | trial_co;

`ifdef SEQ_DIV_SIGNED_EN
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             fix;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] na_in, nb_in;
  logic [WIDTH-1:0] na_out, nb_out;
  logic             na_co_unused;
  logic             nb_co_unused;

  // Negators condition operands in IDLE and fix results in FIX.
  assign fix   = (st_q == DIV_ST_FIX);
  assign na_in = fix ? q_q : DVND;
  assign nb_in = fix ? r_q : DVSR;

  RC_ADD_SUB_32 u_neg_a (
    .Y   (na_out),
    .CO  (na_co_unused),
    .A   ('0),
    .B   (na_in),
    .SnA (1'b1)
  );

  RC_ADD_SUB_32 u_neg_b (
    .Y   (nb_out),
    .CO  (nb_co_unused),
    .A   ('0),
    .B   (nb_in),
    .SnA (1'b1)
  );

  assign sgn_a    = SIGNED & DVND[DATA_INDEX_LIMIT];
  assign sgn_b    = SIGNED & DVSR[DATA_INDEX_LIMIT];
  assign dvnd_abs = sgn_a ? na_out : DVND;
  assign dvsr_abs = sgn_b ? nb_out : DVSR;
  assign quot_fix = neg_q_q ? na_out : q_q;
  assign rem_fix  = neg_r_q ? nb_out : r_q;

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (go) begin
      neg_q_d = sgn_a ^ sgn_b;
      neg_r_d = sgn_a;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic signed_unused;

  assign signed_unused = SIGNED;
  assign dvnd_abs      = DVND;
  assign dvsr_abs      = DVSR;
  assign quot_fix      = q_q;
  assign rem_fix       = r_q;
`endif

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    unique case (st_q)
      DIV_ST_IDLE: begin
        if (go) begin
          q_d   = dvnd_abs;
          d_d   = dvsr_abs;
          r_d   = '0;
          cnt_d = CNT_W'(WIDTH);
          st_d  = DIV_ST_RUN;
        end else if (START) begin
          quot_d = '1;
          rem_d  = DVND;
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      DIV_ST_RUN: begin
        r_d   = accept ? trial : r_sh;
        q_d   = {q_sh[WIDTH-1:1], accept};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          st_d = DIV_ST_FIX;
        end
      end
      DIV_ST_FIX: begin
        quot_d = quot_fix;
        rem_d  = rem_fix;
        dbz_d  = 1'b0;
        done_d = 1'b1;
        st_d   = DIV_ST_IDLE;
      end
      default: st_d = DIV_ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= DIV_ST_IDLE;
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      q_q    <= q_d;
      d_q    <= d_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  assign QUOT        = quot_q;
  assign REM         = rem_q;
  assign DONE        = done_q;
  assign DIV_BY_ZERO = dbz_q;
  assign BUSY        = (st_q != DIV_ST_IDLE);

endmodule

// File: tb/tb_seq_div_32.sv
// Self-checking bench for seq_div_32: vector table, scoreboard, corners.
// Signed expectations follow SEQ_DIV_SIGNED_EN.
module tb_seq_div_32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SIGNED;
  logic [31:0] DVND, DVSR;
  logic [31:0] QUOT, REM;
  logic        DONE, BUSY, DIV_BY_ZERO;

  seq_div_32 dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .DVND        (DVND),
    .DVSR        (DVSR),
    .SIGNED      (SIGNED),
    .QUOT        (QUOT),
    .REM         (REM),
    .DONE        (DONE),
    .BUSY        (BUSY),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got DONE=1, want none");
      end else begin
        mon_e = sb.pop_front();
        check("quot", QUOT, mon_e.q);
        check("rem", REM, mon_e.r);
        check("dbz", 32'(DIV_BY_ZERO), 32'(mon_e.z));
      end
    end
  end

  task automatic add(input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [31:0] q,
                     input logic [31:0] r, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.s = s;
    v.q = q; v.r = r; v.z = z;
    tbl.push_back(v);
  endtask

  task automatic mk(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] q, input logic [31:0] r,
                    output vec_t v);
    v.a = a; v.b = b; v.s = 1'b0;
    v.q = q; v.r = r; v.z = 1'b0;
  endtask

  // Caller sits just after a rising edge; START is held for one edge.
  task automatic start_op(input vec_t v, input bit push);
    exp_t e;
    DVND   = v.a;
    DVSR   = v.b;
    SIGNED = v.s;
    START  = 1'b1;
    if (push) begin
      e.q = v.q; e.r = v.r; e.z = v.z;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    START  = 1'b0;
    DVND   = $urandom;
    DVSR   = $urandom;
    SIGNED = 1'($urandom);
  endtask

  task automatic wait_done(input string nm, input int lat_exp,
                           input int busy_exp);
    int lat;
    int busy;
    lat  = 0;
    busy = (BUSY === 1'b1) ? 1 : 0;
    while (DONE !== 1'b1 && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
      if (BUSY === 1'b1) busy++;
    end
    check({nm, "_done_seen"}, 32'(DONE), 32'd1);
    check({nm, "_latency"}, 32'(lat), 32'(lat_exp));
    check({nm, "_busy_cycles"}, 32'(busy), 32'(busy_exp));
  endtask

  task automatic pulse_chk(input string nm);
    @(posedge CLK);
    #1;
    check({nm, "_done_pulse"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t w;
    RST    = 1'b1;
    START  = 1'b0;
    SIGNED = 1'b0;
    DVND   = '0;
    DVSR   = '0;

    add(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    add(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
    add(32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1);
    add(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    add(32'd5, 32'd100, 1'b0, 32'd0, 32'd5, 1'b0);
    add(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0);
    add(32'h80000000, 32'd3, 1'b0, 32'h2AAAAAAA, 32'd2, 1'b0);
    add(32'hDEADBEEF, 32'h10, 1'b0, 32'h0DEADBEE, 32'hF, 1'b0);
    add(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0);
    add(32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
`ifdef SEQ_DIV_SIGNED_EN
    add(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    add(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
    add(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
    add(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0);
`else
    add(32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0);
    add(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b0);
`endif

    #12;
    check("rst_quot", QUOT, 32'd0);
    check("rst_rem", REM, 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_dbz", 32'(DIV_BY_ZERO), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      start_op(tbl[i], 1'b1);
      if (tbl[i].b == 32'd0) wait_done("vec", 0, 0);
      else                   wait_done("vec", 33, 33);
      pulse_chk("vec");
      check("quot_hold", QUOT, tbl[i].q);
      check("dbz_hold", 32'(DIV_BY_ZERO), 32'(tbl[i].z));
    end

    // START in the DONE cycle must be accepted.
    mk(32'd500, 32'd7, 32'd71, 32'd3, v);
    mk(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, w);
    start_op(v, 1'b1);
    wait_done("b2b_a", 33, 33);
    start_op(w, 1'b1);
    wait_done("b2b_b", 33, 33);
    pulse_chk("b2b_b");

    // START while busy is ignored.
    mk(32'd1000, 32'd33, 32'd30, 32'd10, v);
    mk(32'd5, 32'd0, 32'd0, 32'd0, w);
    start_op(v, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
    start_op(w, 1'b0);
    wait_done("busy_ign", 28, 28);
    pulse_chk("busy_ign");
    repeat (3) @(posedge CLK);
    #1;
    check("busy_ign_quot", QUOT, 32'd30);
    check("busy_ign_dbz", 32'(DIV_BY_ZERO), 32'd0);

    // Async reset ten cycles into RUN discards the op.
    mk(32'd100, 32'd7, 32'd14, 32'd2, v);
    start_op(v, 1'b0);
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_quot", QUOT, 32'd0);
    check("mid_rst_rem", REM, 32'd0);
    check("mid_rst_done", 32'(DONE), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_dbz", 32'(DIV_BY_ZERO), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    check("post_rst_busy", 32'(BUSY), 32'd0);
    check("post_rst_quot", QUOT, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
